// File: rtl/padding_seq_pkg.sv
// Shared constants and state encoding for the zero-padding frame sequencer.
package padding_pkg;

  localparam int IMG_H  = 416;        // image rows without padding
  localparam int IMG_W  = 416;        // image columns without padding
  localparam int PAD_H  = IMG_H + 2;  // rows after adding one zero row on top and bottom
  localparam int ROW_AW = 9;          // row index / counter width (holds 0..PAD_H)

  typedef enum logic [2:0] {
    IDLE,
    ZTOP,
    FETCH,
    WIN,
    ZBOT,
    DONE
  } state_t;

endpackage

// File: rtl/padding_seq_if.sv
// Handshake bundle between the padding sequencer, the row buffer, the padding
// unit and the convolution engine. The sequencer is the master side.
interface padding_seq_if #(
  parameter int ROW_AW = padding_pkg::ROW_AW
);

  logic              start;
  logic              busy;
  logic              done;
  logic              rd_req;
  logic [ROW_AW-1:0] rd_row_addr;
  logic              rd_valid;
  logic              pad_en;
  logic              pad_zero;
  logic              win_valid;
  logic              win_ready;
  logic [ROW_AW-1:0] win_row;

  modport master (
    input  start,
    input  rd_valid,
    input  win_ready,
    output busy,
    output done,
    output rd_req,
    output rd_row_addr,
    output pad_en,
    output pad_zero,
    output win_valid,
    output win_row
  );

  modport slave (
    output start,
    output rd_valid,
    output win_ready,
    input  busy,
    input  done,
    input  rd_req,
    input  rd_row_addr,
    input  pad_en,
    input  pad_zero,
    input  win_valid,
    input  win_row
  );

endinterface

// File: rtl/padding_seq.sv
// Frame sequencer for the first-layer zero-padding datapath: pushes a zero row,
// the image rows in order and a final zero row into the padding unit's 3-row
// register, and presents every complete 3-row window to the conv engine.
module padding_seq #(
  parameter int IMG_H  = padding_pkg::IMG_H,
  parameter int ROW_AW = padding_pkg::ROW_AW
) (
  input  logic          clk,
  input  logic          reset,
  padding_seq_if.master bus
);

  import padding_pkg::*;

  // Constants sized to the counter width so all compares are width-matched.
  localparam logic [ROW_AW-1:0] ONE      = ROW_AW'(1);
  localparam logic [ROW_AW-1:0] WIN_FILL = ROW_AW'(3);          // rows needed for a full window
  localparam logic [ROW_AW-1:0] ALL_ROWS = ROW_AW'(IMG_H);      // img_row after the last fetch
  localparam logic [ROW_AW-1:0] LAST_WIN = ROW_AW'(IMG_H - 1);  // index of the final window

  state_t            state_q, state_d;
  logic [ROW_AW-1:0] img_row_q, img_row_d;      // image rows fetched so far
  logic [ROW_AW-1:0] shift_cnt_q, shift_cnt_d;  // padded rows shifted so far (max IMG_H+2)
  logic [ROW_AW-1:0] win_row_q, win_row_d;      // windows accepted so far

  // Registered, state-decoded outputs; computed from the next state so they
  // line up exactly with state_q in the following cycle.
  logic busy_q;
  logic done_q;
  logic rd_req_q;
  logic win_valid_q;

  // Combinational shift strobes to the padding unit (Mealy on rd_valid in FETCH).
  logic pad_en;
  logic pad_zero;

  // Next-state, counter update and shift-strobe decode.
  always_comb begin
    state_d     = state_q;
    img_row_d   = img_row_q;
    shift_cnt_d = shift_cnt_q;
    win_row_d   = win_row_q;
    pad_en      = 1'b0;
    pad_zero    = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          state_d = ZTOP;
        end
      end

      ZTOP: begin
        // Top zero row is padded row 0.
        pad_en      = 1'b1;
        pad_zero    = 1'b1;
        shift_cnt_d = ONE;
        state_d     = FETCH;
      end

      FETCH: begin
        // Nothing moves until the row buffer has the row on its outputs.
        if (bus.rd_valid) begin
          pad_en      = 1'b1;
          img_row_d   = img_row_q + ONE;
          shift_cnt_d = shift_cnt_q + ONE;
          if (shift_cnt_d >= WIN_FILL) begin
            state_d = WIN;
          end
        end
      end

      WIN: begin
        // Register contents stay frozen here: no shift strobe in this state.
        if (bus.win_ready) begin
          win_row_d = win_row_q + ONE;
          if (win_row_q == LAST_WIN) begin
            state_d = DONE;
          end else if (img_row_q == ALL_ROWS) begin
            state_d = ZBOT;
          end else begin
            state_d = FETCH;
          end
        end
      end

      ZBOT: begin
        // Bottom zero row completes the last window.
        pad_en      = 1'b1;
        pad_zero    = 1'b1;
        shift_cnt_d = shift_cnt_q + ONE;
        state_d     = WIN;
      end

      DONE: begin
        img_row_d   = '0;
        shift_cnt_d = '0;
        win_row_d   = '0;
        state_d     = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State, counters and registered status outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      img_row_q   <= '0;
      shift_cnt_q <= '0;
      win_row_q   <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      rd_req_q    <= 1'b0;
      win_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      img_row_q   <= img_row_d;
      shift_cnt_q <= shift_cnt_d;
      win_row_q   <= win_row_d;
      busy_q      <= (state_d != IDLE);
      done_q      <= (state_d == DONE);
      rd_req_q    <= (state_d == FETCH);
      win_valid_q <= (state_d == WIN);
    end
  end

  assign bus.busy        = busy_q;
  assign bus.done        = done_q;
  assign bus.rd_req      = rd_req_q;
  assign bus.rd_row_addr = img_row_q;
  assign bus.win_valid   = win_valid_q;
  assign bus.win_row     = win_row_q;
  assign bus.pad_en      = pad_en;
  assign bus.pad_zero    = pad_zero;

endmodule

// File: tb/tb_padding_seq.sv
// Bench for padding_seq: a row/window-level model of the padded frame checked
// every cycle, plus literal cycle numbers for the directed scenarios.
module tb_padding_seq;

  localparam int H = 416;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  padding_seq_if #(.ROW_AW(9)) bus ();

  padding_seq #(.IMG_H(H), .ROW_AW(9)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int total = 0;
  int bad   = 0;

  // Cycle bookkeeping shared by stimulus and monitor.
  int cyc      = 0;
  int t0       = 0;
  bit frame_on = 1'b0;
  bit chk_en   = 1'b0;
  int extra    = 0;
  bit dly_en   = 1'b0;
  bit stall_en = 1'b0;
  int dly_cnt  = 0;
  int stall_cnt = 0;

  // Model of the padded frame: ids of rows pushed (-1 = zero row).
  int m_fetch = 0;
  int m_win   = 0;
  int pushed[$];

  // Per-frame observations used by the literal checks.
  int zero_rel[$];
  int done_rel_seen = -1;
  int win_cycles    = 0;
  int first_win_rel = -1;
  int addr5_cyc     = 0;
  int win200_cyc    = 0;
  int done_cnt      = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Padded row j of the frame: zero, image rows 0..H-1, zero.
  function automatic int pid(input int j);
    if (j == 0 || j == H + 1) return -1;
    return j - 1;
  endfunction

  task automatic model_clear();
    m_fetch = 0;
    m_win   = 0;
    pushed.delete();
  endtask

  task automatic clear_stats();
    zero_rel.delete();
    done_rel_seen = -1;
    win_cycles    = 0;
    first_win_rel = -1;
    addr5_cyc     = 0;
    win200_cyc    = 0;
    done_cnt      = 0;
  endtask

  task automatic check_cycle();
    int rel;
    int dr;
    int zr;
    bit eb;
    bit ed;
    bit ez;
    rel = cyc - t0;
    dr  = 835 + extra;
    zr  = 833 + extra;
    if (frame_on && rel == 0) model_clear();
    eb = frame_on && rel >= 1 && rel <= dr;
    ed = frame_on && rel == dr;
    ez = frame_on && (rel == 1 || rel == zr);

    chk("busy", bus.busy, eb);
    chk("done", bus.done, ed);
    chk("pad_zero", bus.pad_zero, ez);
    chk("pad_zero_without_en", bus.pad_zero & ~bus.pad_en, 0);
    chk("pad_en_during_win", bus.pad_en & bus.win_valid, 0);
    chk("rd_req_during_win", bus.rd_req & bus.win_valid, 0);
    if (!eb || ed) begin
      chk("idle_rd_req", bus.rd_req, 0);
      chk("idle_win_valid", bus.win_valid, 0);
      chk("idle_pad_en", bus.pad_en, 0);
    end

    if (bus.rd_req) begin
      chk("rd_row_addr", bus.rd_row_addr, m_fetch);
      if (bus.rd_row_addr == 9'd5) addr5_cyc++;
      if (bus.rd_valid) begin
        chk("fetch_pad_en", bus.pad_en, 1);
        pushed.push_back(m_fetch);
        m_fetch++;
      end else begin
        chk("stalled_fetch_pad_en", bus.pad_en, 0);
      end
    end else if (bus.pad_en === 1'b1 && bus.pad_zero === 1'b1) begin
      chk("zero_row_slot", (pushed.size() == 0 || pushed.size() == H + 1), 1);
      pushed.push_back(-1);
      zero_rel.push_back(rel);
    end else begin
      chk("stray_pad_en", bus.pad_en, 0);
    end

    if (bus.win_valid) begin
      chk("win_row", bus.win_row, m_win);
      chk("win_depth", pushed.size(), m_win + 3);
      for (int j = 0; j < 3; j++) begin
        if (m_win + j < pushed.size()) chk("win_content", pushed[m_win + j], pid(m_win + j));
      end
      if (extra == 0 && m_win <= H - 2) chk("win_time", rel, 4 + 2 * m_win);
      win_cycles++;
      if (first_win_rel < 0) first_win_rel = rel;
      if (bus.win_row == 9'd200) win200_cyc++;
      if (bus.win_ready) m_win++;
    end

    if (bus.done) begin
      done_cnt++;
      done_rel_seen = rel;
      chk("done_windows", m_win, H);
      chk("done_rows", m_fetch, H);
      chk("done_pushes", pushed.size(), H + 2);
    end
  endtask

  // Input driver and per-cycle monitor: drive on the falling edge, check 1 ns later.
  always begin
    @(negedge clk);
    bus.rd_valid = 1'b1;
    if (dly_en && bus.rd_req && bus.rd_row_addr == 9'd5 && dly_cnt < 3) begin
      bus.rd_valid = 1'b0;
      dly_cnt++;
    end
    bus.win_ready = 1'b1;
    if (stall_en && bus.win_valid && bus.win_row == 9'd200 && stall_cnt < 10) begin
      bus.win_ready = 1'b0;
      stall_cnt++;
    end
    #1;
    if (chk_en) check_cycle();
    if (reset) begin
      frame_on = 1'b0;
      model_clear();
    end
    cyc++;
  end

  task automatic start_frame(input int ex);
    @(negedge clk);
    extra     = ex;
    dly_cnt   = 0;
    stall_cnt = 0;
    clear_stats();
    bus.start = 1'b1;
    t0        = cyc;
    frame_on  = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 1500; i++) begin
      @(negedge clk);
      #2;
      if (bus.done === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      total++;
      bad++;
      $display("FAIL %s_timeout: done not seen, required within 1500 cycles", tag);
    end
  endtask

  task automatic check_nominal();
    chk("done_cycle", done_rel_seen, 835);
    chk("done_pulses", done_cnt, 1);
    chk("zero_row_count", zero_rel.size(), 2);
    if (zero_rel.size() == 2) begin
      chk("top_zero_cycle", zero_rel[0], 1);
      chk("bottom_zero_cycle", zero_rel[1], 833);
    end
    chk("win_valid_cycles", win_cycles, 416);
    chk("first_win_cycle", first_win_rel, 4);
    chk("rows_fetched", m_fetch, 416);
  endtask

  task automatic check_all_zero();
    chk("rst_busy", bus.busy, 0);
    chk("rst_done", bus.done, 0);
    chk("rst_rd_req", bus.rd_req, 0);
    chk("rst_rd_row_addr", bus.rd_row_addr, 0);
    chk("rst_pad_en", bus.pad_en, 0);
    chk("rst_pad_zero", bus.pad_zero, 0);
    chk("rst_win_valid", bus.win_valid, 0);
    chk("rst_win_row", bus.win_row, 0);
  endtask

  initial begin
    bit found;
    reset     = 1'b1;
    bus.start = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    #2;
    check_all_zero();
    chk_en = 1'b1;

    // Zero-wait memory, ready always high, spurious rd_valid/win_ready everywhere.
    start_frame(0);
    wait_done("nominal");
    check_nominal();

    // Row 5 arrives three cycles late.
    dly_en = 1'b1;
    start_frame(3);
    wait_done("rd_delay");
    chk("rd_delay_done_cycle", done_rel_seen, 838);
    chk("rd_delay_addr5_cycles", addr5_cyc, 4);
    if (zero_rel.size() == 2) chk("rd_delay_bottom_zero", zero_rel[1], 836);
    dly_en = 1'b0;

    // Window 200 back-pressured for ten cycles.
    stall_en = 1'b1;
    start_frame(10);
    wait_done("win_stall");
    chk("win_stall_done_cycle", done_rel_seen, 845);
    chk("win_stall_win200_cycles", win200_cyc, 11);
    chk("win_stall_win_cycles", win_cycles, 426);
    stall_en = 1'b0;

    // start pulses during FETCH and WIN are ignored; start held through done restarts.
    @(negedge clk);
    extra = 0;
    clear_stats();
    bus.start = 1'b1;
    t0        = cyc;
    frame_on  = 1'b1;
    @(negedge clk); bus.start = 1'b0;
    @(negedge clk); bus.start = 1'b1;
    @(negedge clk); bus.start = 1'b0;
    @(negedge clk); bus.start = 1'b1;
    @(negedge clk); bus.start = 1'b0;
    repeat (825) @(negedge clk);
    bus.start = 1'b1;
    wait_done("start_ignore");
    chk("start_ignore_done_cycle", done_rel_seen, 835);
    chk("start_ignore_done_pulses", done_cnt, 1);
    @(negedge clk);
    t0 = cyc;
    clear_stats();
    @(negedge clk);
    bus.start = 1'b0;
    wait_done("back_to_back");
    check_nominal();

    // Reset while window 100 is presented.
    start_frame(0);
    found = 1'b0;
    for (int i = 0; i < 600; i++) begin
      @(negedge clk);
      #2;
      if (bus.rd_req && bus.rd_valid && bus.rd_row_addr == 9'd101) begin
        found = 1'b1;
        break;
      end
    end
    if (!found) begin
      total++;
      bad++;
      $display("FAIL row101_timeout: fetch of row 101 not seen, required within 600 cycles");
    end
    @(negedge clk);
    reset = 1'b1;
    #2;
    chk("pre_reset_win_valid", bus.win_valid, 1);
    chk("pre_reset_win_row", bus.win_row, 100);
    @(negedge clk);
    reset = 1'b0;
    #2;
    check_all_zero();

    // A fresh frame after the abort runs exactly like the first one.
    start_frame(0);
    wait_done("after_reset");
    check_nominal();

    repeat (3) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/padding_seq.md
# padding_seq

Frame-level sequencer for the zero-padding datapath of the first convolution layer. It fetches the 416 image rows (R/G/B together) from the input row buffer in order and inserts one zero row above and one below the image. Each row is pushed into the padding unit and its 3-row register. Whenever that register holds a complete 3×418 window it presents the window to the convolution engine with a valid/ready handshake.

## Interface
Parameters:
- IMG_H, 416, image rows (unpadded)
- ROW_AW, 9, width of row index/address

Ports:
- clk  in  1  system clock, all logic on rising edge
- reset  in  1  synchronous, active-high; clears all state
- start  in  1  begin one frame; sampled only in IDLE
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse at frame end
- rd_req  out  1  row fetch request to row buffer
- rd_row_addr  out  ROW_AW  image row requested (0..IMG_H-1)
- rd_valid  in  1  requested row present on R/G/B_input this cycle
- pad_en  out  1  shift one padded row into the 3-row register (drives padding `en`)
- pad_zero  out  1  with pad_en: shift an all-zero row instead of R/G/B_input
- win_valid  out  1  3-row window valid at row0/row1/row2 outputs
- win_ready  in  1  conv engine accepts window
- win_row  out  ROW_AW  output row index of presented window (0..IMG_H-1)

## Operation
- Padded image = 418 rows: zero, image rows 0..415, zero. Window k uses padded rows k..k+2, k = 0..415.
- Counters:
  - img_row counts fetched image rows, 0..IMG_H.
  - shift_cnt counts padded rows shifted, 0..IMG_H+2.
  - win_row counts accepted windows.
- States:
  - IDLE: outputs low. start=1 → ZTOP.
  - ZTOP: pad_en=1, pad_zero=1, shift_cnt←1 → FETCH.
  - FETCH: rd_req=1, rd_row_addr=img_row.
    - rd_valid=1 in the same cycle: pad_en=1 (Mealy, combinational from rd_valid), img_row+1, shift_cnt+1. Next state is WIN if the new shift_cnt ≥ 3, else stay in FETCH.
    - rd_valid=0: hold all outputs and counters.
  - WIN: win_valid=1, hold until win_ready. On accept, win_row+1, then:
    - win_row was IMG_H-1 → DONE
    - else img_row==IMG_H → ZBOT
    - else → FETCH
  - ZBOT: pad_en=1, pad_zero=1, shift_cnt+1 → WIN.
  - DONE: done=1 for one cycle → IDLE; counters cleared.
- pad_en is never asserted in WIN, so the window is stable while win_valid=1.
- Ignored inputs:
  - start while busy
  - rd_valid outside FETCH
  - win_ready outside WIN

## Timing
- Reset values: busy=0, done=0, rd_req=0, rd_row_addr=0, pad_en=0, pad_zero=0, win_valid=0, win_row=0; state IDLE; counters 0.
- Reset mid-frame → IDLE next cycle. The padding register contents are not cleared by this block.
- rd_req, rd_row_addr, win_valid, win_row, busy and done are registered (state-decoded); pad_en and pad_zero are the only combinational outputs.
- start at cycle 0 → ZTOP in cycle 1.
- With zero-wait memory (rd_valid=1 whenever rd_req=1) and win_ready tied high:
  - FETCH row0 in cycle 2, row1 in cycle 3
  - window k presented in cycle 4+2k for k ≤ 414
  - ZBOT in cycle 833, window 415 in cycle 834
  - done in cycle 835, IDLE in cycle 836, new start accepted in cycle 836
- Each cycle of rd_valid=0 or win_ready=0 stretches the frame by exactly one cycle.
- Window k data is valid in the same cycle win_valid rises; the shift happened on the preceding edge.
- Widths: all counters are ROW_AW bits. shift_cnt max is 418, so it must not wrap.

## Structure
- Shared package padding_pkg holds:
  - IMG_H, IMG_W=416, PAD_H=IMG_H+2, ROW_AW
  - state enum {IDLE, ZTOP, FETCH, WIN, ZBOT, DONE}
- Single module, no sub-module. It instantiates alongside the existing padding unit and drives its enable and zero-insert.

## Test plan
- Zero-wait memory, win_ready=1, start at cycle 0:
  - rd_row_addr sequence 0..415, each exactly once
  - pad_zero pulses in cycles 1 and 833
  - 416 win_valid cycles, win_row 0..415 in order
  - done in cycle 835
- rd_valid delayed 3 cycles on row 5: rd_req held with addr=5 for 4 cycles, no pad_en until rd_valid, done 3 cycles late.
- win_ready=0 for 10 cycles on window 200: win_valid and win_row=200 held, no pad_en or rd_req in that span, done 10 cycles late.
- start pulsed during FETCH and WIN: ignored, exactly one done. start held high through done: second frame begins cycle 836.
- reset asserted while in WIN (window 100): next cycle all outputs 0, state IDLE. A new start reproduces the full first-scenario sequence from row 0.
- Spurious rd_valid in IDLE/WIN/DONE and win_ready in FETCH: no counter change, no pad_en.
